// File: rtl/dma_priority_resolver_pkg.sv
// Shared types and command-register bit positions for the 8237A-style DMA priority resolver.
package dma_priority_resolver_pkg;

    localparam int NCH = 4;

    localparam int CMD_DISABLE    = 2;
    localparam int CMD_ROTATE     = 4;
    localparam int CMD_DREQ_SENSE = 6;
    localparam int CMD_DACK_SENSE = 7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    typedef logic [1:0] ch_idx_t;

    function automatic logic [NCH-1:0] ch_onehot(input ch_idx_t ch);
        ch_onehot = 4'b0001 << ch;
    endfunction

endpackage

// File: rtl/dma_prio_encoder.sv
// Rotating find-first: returns the first set request scanning upward from ptr_i+1 (mod 4).
module dma_prio_encoder
    import dma_priority_resolver_pkg::*;
(
    input  logic [NCH-1:0] req_i,
    input  ch_idx_t        ptr_i,
    output logic           found_o,
    output ch_idx_t        idx_o
);

    ch_idx_t cand;

    // NOTE: every variable written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = ptr_i;
        for (int k = 1; k <= NCH; k++) begin
            cand = ptr_i + ch_idx_t'(k);
            if (!found_o && req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/dma_priority_resolver.sv
// Request qualification, hold request and one-service grant/DACK sequencing for the 4-channel DMA.
// Optional rotating priority: define DMA_ROTATE_PRIORITY_EN (otherwise fixed ch0 > ch1 > ch2 > ch3).
module dma_priority_resolver
    import dma_priority_resolver_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [3:0] DREQ,
    input  logic       HLDA,
    input  logic       EOP_N,
    input  logic [7:0] cmd_reg,
    input  logic [3:0] mask_reg,
    input  logic [3:0] sw_req,
    input  logic [3:0] tc,
    input  logic [3:0] autoinit,
    input  logic       svc_start,
    input  logic       svc_done,
    output logic [3:0] valid_dreq,
    output logic       hrq,
    output logic [1:0] grant_ch,
    output logic       grant_vld,
    output logic [3:0] DACK,
    output logic [3:0] clr_sw_req,
    output logic [3:0] set_mask
);

    arb_state_t state_q, state_d;
    logic [3:0] dreq_q;
    logic       hrq_q, hrq_d;
    logic       grant_vld_q, grant_vld_d;
    ch_idx_t    grant_ch_q, grant_ch_d;
    logic [3:0] dack_oh_q, dack_oh_d;
    logic [3:0] clr_q, clr_d;
    logic [3:0] setm_q, setm_d;
    ch_idx_t    prio_ptr;
    logic       win_found;
    ch_idx_t    win_idx;
    logic       svc_end;

    // Pins are normalised to active-high at capture, so everything downstream is polarity-free.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            dreq_q <= '0;
        end else begin
            dreq_q <= DREQ ^ {4{cmd_reg[CMD_DREQ_SENSE]}};
        end
    end

    assign valid_dreq = cmd_reg[CMD_DISABLE] ? 4'b0000 : ((dreq_q & ~mask_reg) | sw_req);

`ifdef DMA_ROTATE_PRIORITY_EN
    ch_idx_t prio_ptr_q, prio_ptr_d;

    always_comb begin
        prio_ptr_d = prio_ptr_q;
        if (state_q == RELEASE && cmd_reg[CMD_ROTATE]) begin
            prio_ptr_d = grant_ch_q;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            prio_ptr_q <= 2'd3;
        end else begin
            prio_ptr_q <= prio_ptr_d;
        end
    end

    assign prio_ptr = cmd_reg[CMD_ROTATE] ? prio_ptr_q : 2'd3;

    logic unused_cmd_bits;
    assign unused_cmd_bits = ^{cmd_reg[5], cmd_reg[3], cmd_reg[1:0]};
`else
    assign prio_ptr = 2'd3;

    logic unused_cmd_bits;
    assign unused_cmd_bits = ^{cmd_reg[5:3], cmd_reg[1:0]};
`endif

    dma_prio_encoder u_prio_encoder (
        .req_i   (valid_dreq),
        .ptr_i   (prio_ptr),
        .found_o (win_found),
        .idx_o   (win_idx)
    );

    assign svc_end = svc_done || !EOP_N;

    always_comb begin
        state_d    = state_q;
        grant_ch_d = grant_ch_q;
        dack_oh_d  = dack_oh_q;
        clr_d      = '0;
        setm_d     = '0;

        unique case (state_q)
            IDLE: begin
                if (|valid_dreq) state_d = REQ;
            end
            REQ: begin
                // The winner is re-evaluated every cycle until HLDA freezes it.
                if (valid_dreq == 4'b0000) begin
                    state_d = IDLE;
                end else if (HLDA && win_found) begin
                    state_d    = SERVICE;
                    grant_ch_d = win_idx;
                end
            end
            SERVICE: begin
                if (svc_start) dack_oh_d = ch_onehot(grant_ch_q);
                if (svc_end) begin
                    state_d   = RELEASE;
                    dack_oh_d = '0;
                    clr_d     = ch_onehot(grant_ch_q);
                    if ((tc[grant_ch_q] || !EOP_N) && !autoinit[grant_ch_q]) begin
                        setm_d = ch_onehot(grant_ch_q);
                    end
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        hrq_d       = (state_d == REQ) || (state_d == SERVICE);
        grant_vld_d = (state_d == SERVICE);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            hrq_q       <= 1'b0;
            grant_vld_q <= 1'b0;
            grant_ch_q  <= '0;
            dack_oh_q   <= '0;
            clr_q       <= '0;
            setm_q      <= '0;
        end else begin
            state_q     <= state_d;
            hrq_q       <= hrq_d;
            grant_vld_q <= grant_vld_d;
            grant_ch_q  <= grant_ch_d;
            dack_oh_q   <= dack_oh_d;
            clr_q       <= clr_d;
            setm_q      <= setm_d;
        end
    end

    assign hrq        = hrq_q;
    assign grant_vld  = grant_vld_q;
    assign grant_ch   = grant_ch_q;
    assign DACK       = dack_oh_q ^ {4{~cmd_reg[CMD_DACK_SENSE]}};
    assign clr_sw_req = clr_q;
    assign set_mask   = setm_q;

endmodule

// File: tb/tb_dma_priority_resolver.sv
// Scoreboard bench for dma_priority_resolver: directed spec cases plus randomized services vs a behavioural model.
module tb_dma_priority_resolver;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b1;
    logic [3:0] DREQ = 4'b0000;
    logic       HLDA = 1'b0;
    logic       EOP_N = 1'b1;
    logic [7:0] cmd_reg = 8'h00;
    logic [3:0] mask_reg = 4'b0000;
    logic [3:0] sw_req = 4'b0000;
    logic [3:0] tc = 4'b0000;
    logic [3:0] autoinit = 4'b0000;
    logic       svc_start = 1'b0;
    logic       svc_done = 1'b0;
    logic [3:0] valid_dreq;
    logic       hrq;
    logic [1:0] grant_ch;
    logic       grant_vld;
    logic [3:0] DACK;
    logic [3:0] clr_sw_req;
    logic [3:0] set_mask;

    dma_priority_resolver dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .DREQ       (DREQ),
        .HLDA       (HLDA),
        .EOP_N      (EOP_N),
        .cmd_reg    (cmd_reg),
        .mask_reg   (mask_reg),
        .sw_req     (sw_req),
        .tc         (tc),
        .autoinit   (autoinit),
        .svc_start  (svc_start),
        .svc_done   (svc_done),
        .valid_dreq (valid_dreq),
        .hrq        (hrq),
        .grant_ch   (grant_ch),
        .grant_vld  (grant_vld),
        .DACK       (DACK),
        .clr_sw_req (clr_sw_req),
        .set_mask   (set_mask)
    );

    always #5 CLK = ~CLK;

`ifdef DMA_ROTATE_PRIORITY_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    typedef struct {
        logic [1:0] ch;
        logic [3:0] dack;
        logic [3:0] clr;
        logic [3:0] setm;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   model_ptr = 3;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Highest-priority pending channel: first requester after the last-served one, wrapping.
    function automatic int model_winner(input logic [3:0] v, input int ptr);
        for (int k = 1; k <= 4; k++) begin
            if (v[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic recover();
        RESET_N = 1'b0;
        HLDA = 1'b0; svc_start = 1'b0; svc_done = 1'b0; EOP_N = 1'b1;
        DREQ = 4'b0000; sw_req = 4'b0000; cmd_reg = 8'h00;
        exp_q.delete();
        model_ptr = 3;
        tick();
        RESET_N = 1'b1;
        tick();
    endtask

    // end_mode: 0 = svc_done, 1 = EOP_N low, 2 = both together
    task automatic do_service(input logic [3:0] req, input logic [3:0] mask, input logic [3:0] sw,
                              input logic [7:0] cmd, input logic [3:0] t, input logic [3:0] ai,
                              input int end_mode, input int hdly, input bit early_drop);
        logic [3:0] v;
        logic [3:0] oh;
        int         w;
        int         ptr_eff;
        int         n;
        exp_t       e;
        cmd_reg  = cmd;
        mask_reg = mask;
        sw_req   = sw;
        tc       = t;
        autoinit = ai;
        DREQ     = req ^ {4{cmd[6]}};
        v        = cmd[2] ? 4'b0000 : ((req & ~mask) | sw);
        ptr_eff  = (ROT_EN && cmd[4]) ? model_ptr : 3;
        w        = model_winner(v, ptr_eff);
        tick();
        tick();
        check("valid_dreq", {4'b0, valid_dreq}, {4'b0, v});
        check("hrq_after_request", {7'b0, hrq}, {7'b0, (v != 4'b0000)});
        if (v == 4'b0000) begin
            tick();
            tick();
            check("hrq_stays_low", {7'b0, hrq}, 8'h00);
            check("grant_vld_stays_low", {7'b0, grant_vld}, 8'h00);
            DREQ = {4{cmd[6]}};
            sw_req = 4'b0000;
            tick();
            return;
        end
        oh     = 4'b0001 << w;
        e.ch   = w[1:0];
        e.dack = oh ^ {4{~cmd[7]}};
        e.clr  = oh;
        e.setm = ((t[w] || end_mode != 0) && !ai[w]) ? oh : 4'b0000;
        exp_q.push_back(e);
        repeat (hdly) tick();
        HLDA = 1'b1;
        for (n = 0; n < 10 && !grant_vld; n++) tick();
        if (!grant_vld) begin
            check("grant_timeout", {7'b0, grant_vld}, 8'h01);
            recover();
            return;
        end
        svc_start = 1'b1;
        tick();
        svc_start = 1'b0;
        if (early_drop) HLDA = 1'b0;
        tick();
        check("grant_held_in_service", {7'b0, grant_vld}, 8'h01);
        DREQ   = {4{cmd[6]}};
        sw_req = 4'b0000;
        if (end_mode != 0) EOP_N = 1'b0;
        if (end_mode != 1) svc_done = 1'b1;
        tick();
        svc_done = 1'b0;
        EOP_N    = 1'b1;
        HLDA     = 1'b0;
        check("hrq_in_release", {7'b0, hrq}, 8'h00);
        check("dack_idle_in_release", {4'b0, DACK}, {4'b0, {4{~cmd[7]}}});
        tick();
        check("hrq_idle_after_release", {7'b0, hrq}, 8'h00);
        if (ROT_EN && cmd[4]) model_ptr = w;
    endtask

    // Monitor: compares DUT-presented grants, acknowledges and release pulses against the queue.
    logic gv_prev = 1'b0;
    logic start_seen = 1'b0;
    always @(negedge CLK) begin
        if (!RESET_N) begin
            gv_prev = 1'b0;
            start_seen = 1'b0;
        end else begin
            if (grant_vld && !gv_prev) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL grant_unexpected: got ch %0d expected no grant", grant_ch);
                end else begin
                    check("grant_ch", {6'b0, grant_ch}, {6'b0, exp_q[0].ch});
                end
            end
            if (start_seen && exp_q.size() != 0) begin
                check("dack", {4'b0, DACK}, {4'b0, exp_q[0].dack});
            end
            start_seen = svc_start && grant_vld;
            if (clr_sw_req != 4'b0000 || set_mask != 4'b0000) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL release_unexpected: got clr %b set_mask %b expected none", clr_sw_req, set_mask);
                end else begin
                    check("clr_sw_req", {4'b0, clr_sw_req}, {4'b0, exp_q[0].clr});
                    check("set_mask", {4'b0, set_mask}, {4'b0, exp_q[0].setm});
                    void'(exp_q.pop_front());
                end
            end
            gv_prev = grant_vld;
        end
    end

    initial begin
        exp_t e;
        int   n;
        logic [7:0] rc;
        #1 RESET_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_hrq", {7'b0, hrq}, 8'h00);
        check("rst_grant_vld", {7'b0, grant_vld}, 8'h00);
        check("rst_grant_ch", {6'b0, grant_ch}, 8'h00);
        check("rst_dack", {4'b0, DACK}, 8'h0f);
        check("rst_clr_sw_req", {4'b0, clr_sw_req}, 8'h00);
        check("rst_set_mask", {4'b0, set_mask}, 8'h00);
        check("rst_valid_dreq", {4'b0, valid_dreq}, 8'h00);
        RESET_N = 1'b1;
        tick();

        // Fixed priority: ch0 beats ch2; then ch2 alone.
        do_service(4'b0101, 4'b0000, 4'b0000, 8'h00, 4'b0000, 4'b0000, 0, 2, 1'b0);
        do_service(4'b0100, 4'b0000, 4'b0000, 8'h00, 4'b0000, 4'b0000, 0, 1, 1'b0);

        // Rotating request set held across five services.
        for (int i = 0; i < 5; i++)
            do_service(4'b1111, 4'b0000, 4'b0000, 8'h10, 4'b0000, 4'b0000, 0, 0, 1'b0);

        // Mask blocks the pin, software request bypasses the mask.
        do_service(4'b0001, 4'b0001, 4'b0000, 8'h00, 4'b0000, 4'b0000, 0, 0, 1'b0);
        do_service(4'b0001, 4'b0001, 4'b0001, 8'h00, 4'b0000, 4'b0000, 0, 1, 1'b0);

        // Terminal count with and without autoinit.
        do_service(4'b0010, 4'b0000, 4'b0000, 8'h00, 4'b0010, 4'b0000, 0, 0, 1'b0);
        do_service(4'b0010, 4'b0000, 4'b0000, 8'h00, 4'b0010, 4'b0010, 0, 0, 1'b0);

        // Inverted pin senses: pins 1011 -> ch2, DACK active high.
        do_service(4'b0100, 4'b0000, 4'b0000, 8'hC0, 4'b0000, 4'b0000, 0, 0, 1'b0);

        // EOP termination, and EOP together with svc_done, with HLDA dropped early.
        do_service(4'b1000, 4'b0000, 4'b0000, 8'h00, 4'b0000, 4'b0000, 1, 0, 1'b1);
        do_service(4'b1000, 4'b0000, 4'b0000, 8'h00, 4'b0000, 4'b0000, 2, 1, 1'b0);

        // Controller disable suppresses both pins and software requests.
        do_service(4'b1111, 4'b0000, 4'b1111, 8'h04, 4'b0000, 4'b0000, 0, 0, 1'b0);

        // Asynchronous reset in the middle of a service.
        cmd_reg = 8'h00; mask_reg = 4'b0000; sw_req = 4'b0000;
        DREQ = 4'b1000;
        e.ch = 2'd3; e.dack = 4'b0111; e.clr = 4'b1000; e.setm = 4'b0000;
        exp_q.push_back(e);
        tick(); tick();
        HLDA = 1'b1;
        for (n = 0; n < 10 && !grant_vld; n++) tick();
        check("mid_reset_reached_service", {7'b0, grant_vld}, 8'h01);
        svc_start = 1'b1;
        tick();
        svc_start = 1'b0;
        tick();
        RESET_N = 1'b0;
        #1;
        check("mid_reset_hrq", {7'b0, hrq}, 8'h00);
        check("mid_reset_grant_vld", {7'b0, grant_vld}, 8'h00);
        check("mid_reset_dack", {4'b0, DACK}, 8'h0f);
        check("mid_reset_grant_ch", {6'b0, grant_ch}, 8'h00);
        exp_q.delete();
        model_ptr = 3;
        HLDA = 1'b0; DREQ = 4'b0000;
        tick();
        RESET_N = 1'b1;
        tick();

        // Randomized services.
        for (int i = 0; i < 60; i++) begin
            rc = 8'($urandom);
            rc[2] = ($urandom_range(7) == 0);
            do_service(4'($urandom), 4'($urandom), ($urandom_range(3) == 0) ? 4'($urandom) : 4'b0000,
                       rc, 4'($urandom), 4'($urandom), int'($urandom_range(2)),
                       int'($urandom_range(3)), bit'($urandom_range(1)));
        end

        tick(); tick(); tick();
        check("scoreboard_drain", 8'(exp_q.size()), 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
